id_ex_ctrl_stage: RTL and testbench
===================================

Name: id_ex_ctrl_stage

Overview:
Decode-and-register stage that drives the execute-stage ALU. It takes a fetched RV32I instruction, decodes it into ALU control (alu_op, alub_sel), the sign-extended immediate, register addresses and writeback/memory/branch controls, then registers everything into the ID/EX pipeline boundary. It also handles stall, flush and bubble insertion on behalf of the hazard unit.

Parameters:
XLEN, 32, datapath and immediate width
RESET_PC_VALID, 0, out_valid value after reset (fixed 0; kept as a parameter for bench override only)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  IF/ID holds a real instruction
inst  input  32  instruction word
in_pc  input  32  PC of inst
stall  input  1  hold ID/EX contents (from hazard unit)
flush  input  1  kill next ID/EX contents (branch/jump taken)
out_valid  output  1  ID/EX holds a real instruction
out_pc  output  32  registered PC
rs1_addr  output  5  source register 1 (forced 0 for LUI)
rs2_addr  output  5  source register 2 (0 when unused)
rd_addr  output  5  destination register (0 when rf_we=0)
imm  output  32  sign-extended immediate (I/S/B/U/J by format)
alub_sel  output  1  1: ALU operand B = imm; 0: = rs2 data
alu_op  output  4  ALU operation code
rf_we  output  1  register-file write enable
wd_sel  output  2  writeback source: 0 ALU, 1 memory, 2 PC+4, 3 imm
mem_we  output  1  store
is_branch  output  1  conditional branch; ALU bf decides
is_jal  output  1  JAL
is_jalr  output  1  JALR
illegal  output  1  one-cycle pulse: unsupported encoding was consumed

Behaviour:
- All outputs are registered. Reset (rst_n=0 at posedge) clears every output to 0. Reset wins over stall and flush.
- Latency is 1 cycle: inst is sampled at posedge N and appears on the outputs after posedge N.
- Update priority per posedge: reset > flush > stall > load.
  - flush: load a bubble (all outputs 0, out_valid=0).
  - stall: hold all outputs, except that illegal drops to 0.
  - load: if in_valid=0, load a bubble; otherwise load the decoded fields with out_valid=1.
- alu_op encoding (shared package): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, BEQ=8, BNE=9, BLT=10, BGE=11.
- R-type (0110011):
  - funct3/funct7 000/00→ADD, 000/20→SUB, 111/00→AND, 110/00→OR, 100/00→XOR, 001/00→SLL, 101/00→SRL, 101/20→SRA.
  - alub_sel=0, rf_we=1, wd_sel=0.
- I-ALU (0010011): ADDI, ANDI, ORI, XORI; SLLI/SRLI/SRAI with funct7 check (00/00/20). alub_sel=1, I-imm, rs2=0.
- LW (0000011, f3=010): ADD, alub_sel=1, wd_sel=1, rf_we=1.
- SW (0100011, f3=010): ADD, alub_sel=1, S-imm, mem_we=1, rd=0.
- Branch (1100011):
  - f3 000/001/100/101 → BEQ/BNE/BLT/BGE.
  - alub_sel=0, B-imm (bit0=0), is_branch=1, rf_we=0.
- LUI (0110111): U-imm, rs1=0, alu_op=ADD, alub_sel=1, wd_sel=3, rf_we=1.
- JAL (1101111): J-imm, is_jal=1, wd_sel=2, rf_we=1, alu_op=ADD.
- JALR (1100111, f3=000): I-imm, ADD, alub_sel=1, is_jalr=1, wd_sel=2, rf_we=1.
- Any other encoding, including unsupported funct combinations (e.g. SLT, BLTU):
  - load a bubble (out_valid=0, controls 0) and set illegal=1 for that cycle only.
  - If illegal coincides with flush, flush wins and illegal stays 0.
- rd=x0 with rf_we=1 is passed through unchanged; the register file ignores the write.
- Immediates are always sign-extended from bit 31 of inst. There is no zero-extension path.

Decomposition:
- Shared package/defines holds:
  - alu_op codes (the same macro names the ALU uses).
  - Opcode constants.
  - wd_sel codes.
- One combinational sub-module, imm_gen (inst → 32-bit imm by format), is natural. The decode case and the pipeline register stay in this module.

Test Plan:
- 0x002081B3 (add x3,x1,x2), in_valid=1 → next cycle out_valid=1, alu_op=0, alub_sel=0, rs1=1, rs2=2, rd=3, rf_we=1, wd_sel=0. Then 0x402081B3 → alu_op=1.
- 0xFFF00093 (addi x1,x0,-1) → imm=0xFFFFFFFF, alub_sel=1, alu_op=0, rd=1. Then 0x00208463 (beq x1,x2,+8) → alu_op=8, imm=8, is_branch=1, rf_we=0, rd=0.
- 0x0020A223 (sw x2,4(x1)) → mem_we=1, imm=4, alub_sel=1, rf_we=0. Then 0x123452B7 (lui x5) → imm=0x12345000, rs1=0, wd_sel=3, rd=5.
- Load add, then assert stall 3 cycles while inst changes → outputs frozen. Then stall=1 and flush=1 together → bubble (out_valid=0, all controls 0).
- inst=0x00000000, in_valid=1 → out_valid=0, illegal=1 for exactly one cycle. The same word with flush=1 → illegal=0.
- Mid-stream rst_n=0 for one cycle while in_valid=1 and stall=1 → all outputs 0. Normal decode resumes on the next cycle.

Source files
------------

// File: rtl/id_ex_ctrl_stage_pkg.sv
// Shared decode constants for the ID/EX control stage: ALU op codes, opcodes,
// writeback selects and the registered control bundle.
package id_ex_ctrl_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_BEQ = 4'd8,
    ALU_BNE = 4'd9,
    ALU_BLT = 4'd10,
    ALU_BGE = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC4 = 2'd2,
    WD_IMM = 2'd3
  } wd_sel_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       alub_sel;
    alu_op_e    alu_op;
    logic       rf_we;
    wd_sel_e    wd_sel;
    logic       mem_we;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
  } ctrl_t;

endpackage

// File: rtl/id_ex_ctrl_stage_if.sv
// IF/ID-side inputs, hazard controls and the registered ID/EX outputs.
interface id_ex_ctrl_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] in_pc;
  logic            stall;
  logic            flush;

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] imm;
  logic            alub_sel;
  logic [3:0]      alu_op;
  logic            rf_we;
  logic [1:0]      wd_sel;
  logic            mem_we;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic            illegal;

  modport master (
    output in_valid, inst, in_pc, stall, flush,
    input  out_valid, out_pc, rs1_addr, rs2_addr, rd_addr, imm, alub_sel,
           alu_op, rf_we, wd_sel, mem_we, is_branch, is_jal, is_jalr, illegal
  );

  modport slave (
    input  in_valid, inst, in_pc, stall, flush,
    output out_valid, out_pc, rs1_addr, rs2_addr, rd_addr, imm, alub_sel,
           alu_op, rf_we, wd_sel, mem_we, is_branch, is_jal, is_jalr, illegal
  );
endinterface

// File: rtl/id_ex_ctrl_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J layout from the opcode and
// sign-extends from inst[31]; formats without an immediate yield 0.
module id_ex_ctrl_stage_imm_gen
  import id_ex_ctrl_stage_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm
);
  logic w_s;
  assign w_s = i_inst[31];

  always_comb begin
    // NOTE: o_imm is defaulted before the case so unlisted opcodes cannot infer a latch.
    o_imm = '0;
    case (i_inst[6:0])
      OPC_IALU, OPC_LOAD, OPC_JALR: o_imm = {{20{w_s}}, i_inst[31:20]};
      OPC_STORE:  o_imm = {{20{w_s}}, i_inst[31:25], i_inst[11:7]};
      OPC_BRANCH: o_imm = {{19{w_s}}, w_s, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      OPC_LUI:    o_imm = {i_inst[31:12], 12'b0};
      OPC_JAL:    o_imm = {{11{w_s}}, w_s, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default:    o_imm = '0;
    endcase
  end
endmodule

// File: rtl/id_ex_ctrl_stage.sv
// RV32I decode plus ID/EX pipeline register with stall, flush and bubble
// insertion; unsupported encodings become a bubble with a one-cycle illegal pulse.
module id_ex_ctrl_stage
  import id_ex_ctrl_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit RESET_PC_VALID = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  id_ex_ctrl_stage_if.slave  bus
);
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  ctrl_t           w_ctrl;
  logic            w_legal;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  ctrl_t           r_ctrl;
  logic [XLEN-1:0] r_imm;
  logic            r_illegal;

  assign w_opcode = bus.inst[6:0];
  assign w_funct3 = bus.inst[14:12];
  assign w_funct7 = bus.inst[31:25];

  id_ex_ctrl_stage_imm_gen u_imm_gen (
    .i_inst (bus.inst),
    .o_imm  (w_imm32)
  );

  assign w_imm = XLEN'($signed(w_imm32));

  always_comb begin
    w_ctrl     = '0;
    w_legal    = 1'b0;
    w_ctrl.rs1 = bus.inst[19:15];
    w_ctrl.rd  = bus.inst[11:7];
    case (w_opcode)
      OPC_RTYPE: begin
        w_ctrl.rs2   = bus.inst[24:20];
        w_ctrl.rf_we = 1'b1;
        w_legal      = 1'b1;
        case ({w_funct7, w_funct3})
          {F7_BASE, 3'b000}: w_ctrl.alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: w_ctrl.alu_op = ALU_SUB;
          {F7_BASE, 3'b111}: w_ctrl.alu_op = ALU_AND;
          {F7_BASE, 3'b110}: w_ctrl.alu_op = ALU_OR;
          {F7_BASE, 3'b100}: w_ctrl.alu_op = ALU_XOR;
          {F7_BASE, 3'b001}: w_ctrl.alu_op = ALU_SLL;
          {F7_BASE, 3'b101}: w_ctrl.alu_op = ALU_SRL;
          {F7_ALT,  3'b101}: w_ctrl.alu_op = ALU_SRA;
          default:           w_legal       = 1'b0;
        endcase
      end
      OPC_IALU: begin
        w_ctrl.alub_sel = 1'b1;
        w_ctrl.rf_we    = 1'b1;
        w_legal         = 1'b1;
        case (w_funct3)
          3'b000:  w_ctrl.alu_op = ALU_ADD;
          3'b111:  w_ctrl.alu_op = ALU_AND;
          3'b110:  w_ctrl.alu_op = ALU_OR;
          3'b100:  w_ctrl.alu_op = ALU_XOR;
          3'b001: begin
            w_ctrl.alu_op = ALU_SLL;
            w_legal       = (w_funct7 == F7_BASE);
          end
          3'b101: begin
            w_ctrl.alu_op = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_legal       = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
          end
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_ctrl.alub_sel = 1'b1;
        w_ctrl.rf_we    = 1'b1;
        w_ctrl.wd_sel   = WD_MEM;
        w_legal         = (w_funct3 == 3'b010);
      end
      OPC_STORE: begin
        w_ctrl.rs2      = bus.inst[24:20];
        w_ctrl.rd       = '0;
        w_ctrl.alub_sel = 1'b1;
        w_ctrl.mem_we   = 1'b1;
        w_legal         = (w_funct3 == 3'b010);
      end
      OPC_BRANCH: begin
        w_ctrl.rs2       = bus.inst[24:20];
        w_ctrl.rd        = '0;
        w_ctrl.is_branch = 1'b1;
        w_legal          = 1'b1;
        case (w_funct3)
          3'b000:  w_ctrl.alu_op = ALU_BEQ;
          3'b001:  w_ctrl.alu_op = ALU_BNE;
          3'b100:  w_ctrl.alu_op = ALU_BLT;
          3'b101:  w_ctrl.alu_op = ALU_BGE;
          default: w_legal       = 1'b0;
        endcase
      end
      OPC_LUI: begin
        w_ctrl.rs1      = '0;
        w_ctrl.alub_sel = 1'b1;
        w_ctrl.rf_we    = 1'b1;
        w_ctrl.wd_sel   = WD_IMM;
        w_legal         = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.is_jal = 1'b1;
        w_ctrl.rf_we  = 1'b1;
        w_ctrl.wd_sel = WD_PC4;
        w_legal       = 1'b1;
      end
      OPC_JALR: begin
        w_ctrl.alub_sel = 1'b1;
        w_ctrl.is_jalr  = 1'b1;
        w_ctrl.rf_we    = 1'b1;
        w_ctrl.wd_sel   = WD_PC4;
        w_legal         = (w_funct3 == 3'b000);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Priority: reset > flush > stall > load; a stall only clears the illegal pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_valid   <= RESET_PC_VALID;
      r_pc      <= '0;
      r_ctrl    <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_ctrl    <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else if (bus.stall) begin
      r_illegal <= 1'b0;
    end else if (!bus.in_valid || !w_legal) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_ctrl    <= '0;
      r_imm     <= '0;
      r_illegal <= bus.in_valid;
    end else begin
      r_valid   <= 1'b1;
      r_pc      <= bus.in_pc;
      r_ctrl    <= w_ctrl;
      r_imm     <= w_imm;
      r_illegal <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_pc    = r_pc;
  assign bus.rs1_addr  = r_ctrl.rs1;
  assign bus.rs2_addr  = r_ctrl.rs2;
  assign bus.rd_addr   = r_ctrl.rd;
  assign bus.imm       = r_imm;
  assign bus.alub_sel  = r_ctrl.alub_sel;
  assign bus.alu_op    = r_ctrl.alu_op;
  assign bus.rf_we     = r_ctrl.rf_we;
  assign bus.wd_sel    = r_ctrl.wd_sel;
  assign bus.mem_we    = r_ctrl.mem_we;
  assign bus.is_branch = r_ctrl.is_branch;
  assign bus.is_jal    = r_ctrl.is_jal;
  assign bus.is_jalr   = r_ctrl.is_jalr;
  assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Bench for id_ex_ctrl_stage: directed scenarios plus random streams checked
// against a table-driven RV32I decode model.
module tb_id_ex_ctrl_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alub;
    logic [3:0]  op;
    logic        rfwe;
    logic [1:0]  wd;
    logic        memwe;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  exp_t exp_s = '0;

  int unsigned r_ops [int unsigned];
  int unsigned i_ops [int unsigned];
  int unsigned b_ops [int unsigned];

  always #5 clk = ~clk;

  id_ex_ctrl_stage_if #(.XLEN(32)) bus ();

  id_ex_ctrl_stage #(.XLEN(32), .RESET_PC_VALID(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc,
                                        output bit legal);
    exp_t d = '0;
    logic [6:0] opc = w[6:0];
    int unsigned f3 = w[14:12];
    int unsigned key = (int'(w[31:25]) << 3) | f3;
    logic [31:0] i_imm = 32'($signed(w) >>> 20);
    legal = 1'b0;
    d.valid = 1'b1;
    d.pc    = pc;
    d.rs1   = w[19:15];
    d.rd    = w[11:7];
    if (opc == 7'h33 && r_ops.exists(key)) begin
      legal = 1; d.rs2 = w[24:20]; d.op = 4'(r_ops[key]); d.rfwe = 1;
    end else if (opc == 7'h13 && (f3 == 1 || f3 == 5) && i_ops.exists(key)) begin
      legal = 1; d.op = 4'(i_ops[key]); d.imm = i_imm; d.alub = 1; d.rfwe = 1;
    end else if (opc == 7'h13 && f3 != 1 && f3 != 5 && i_ops.exists(f3)) begin
      legal = 1; d.op = 4'(i_ops[f3]); d.imm = i_imm; d.alub = 1; d.rfwe = 1;
    end else if (opc == 7'h03 && f3 == 2) begin
      legal = 1; d.imm = i_imm; d.alub = 1; d.rfwe = 1; d.wd = 1;
    end else if (opc == 7'h23 && f3 == 2) begin
      legal = 1; d.rs2 = w[24:20]; d.rd = 0; d.alub = 1; d.memwe = 1;
      d.imm = (i_imm & ~32'h1F) | 32'(w[11:7]);
    end else if (opc == 7'h63 && b_ops.exists(f3)) begin
      legal = 1; d.rs2 = w[24:20]; d.rd = 0; d.br = 1; d.op = 4'(b_ops[f3]);
      d.imm = (w[31] ? 32'hFFFF_F000 : 32'h0) | (32'(w[7]) << 11) |
              (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    end else if (opc == 7'h37) begin
      legal = 1; d.rs1 = 0; d.imm = w & 32'hFFFF_F000; d.alub = 1; d.rfwe = 1; d.wd = 3;
    end else if (opc == 7'h6F) begin
      legal = 1; d.jal = 1; d.rfwe = 1; d.wd = 2;
      d.imm = (w[31] ? 32'hFFF0_0000 : 32'h0) | (32'(w[19:12]) << 12) |
              (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    end else if (opc == 7'h67 && f3 == 0) begin
      legal = 1; d.imm = i_imm; d.alub = 1; d.jalr = 1; d.rfwe = 1; d.wd = 2;
    end
    return d;
  endfunction

  function automatic exp_t model_next(input exp_t cur);
    exp_t n = '0;
    bit   legal;
    if (!rst_n || bus.flush) return '0;
    if (bus.stall) begin
      n = cur;
      n.illegal = 1'b0;
      return n;
    end
    if (!bus.in_valid) return '0;
    n = model_decode(bus.inst, bus.in_pc, legal);
    if (!legal) begin
      n = '0;
      n.illegal = 1'b1;
    end
    return n;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.valid = bus.out_valid;  o.pc = bus.out_pc;     o.rs1 = bus.rs1_addr;
    o.rs2 = bus.rs2_addr;     o.rd = bus.rd_addr;    o.imm = bus.imm;
    o.alub = bus.alub_sel;    o.op = bus.alu_op;     o.rfwe = bus.rf_we;
    o.wd = bus.wd_sel;        o.memwe = bus.mem_we;  o.br = bus.is_branch;
    o.jal = bus.is_jal;       o.jalr = bus.is_jalr;  o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67};
    logic [31:0] w = $urandom;
    int unsigned k = $urandom_range(0, 9);
    if (k < 8) w[6:0] = opcs[k];
    if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 1) != 0 && (w[6:0] == 7'h03 || w[6:0] == 7'h23)) w[14:12] = 3'd2;
    if ($urandom_range(0, 1) != 0 && w[6:0] == 7'h67) w[14:12] = 3'd0;
    return w;
  endfunction

  task automatic drive(input bit v, input logic [31:0] w, input bit st, input bit fl);
    bus.in_valid = v;
    bus.inst     = w;
    bus.in_pc    = $urandom & 32'hFFFF_FFFC;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  task automatic tick();
    exp_s = model_next(exp_s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 32'h002081B3, 0, 0);
    tick();
    tick();
    total++;
    if (observe() !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", observe());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    drive(1, 32'h002081B3, 0, 0);
    tick();
    total++;
    if (observe() !== exp_s || bus.alu_op !== 4'd0 || bus.rd_addr !== 5'd3 ||
        bus.rs2_addr !== 5'd2 || bus.rf_we !== 1'b1 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL add got=%h exp=%h", observe(), exp_s);
    end
    drive(1, 32'h402081B3, 0, 0);
    tick();
    total++;
    if (observe() !== exp_s || bus.alu_op !== 4'd1) begin
      bad++;
      $display("FAIL sub got=%h exp=%h", observe(), exp_s);
    end
  endtask

  task automatic test_imm_branch();
    drive(1, 32'hFFF00093, 0, 0);
    tick();
    total++;
    if (observe() !== exp_s || bus.imm !== 32'hFFFF_FFFF || bus.alub_sel !== 1'b1 ||
        bus.rd_addr !== 5'd1 || bus.rs2_addr !== 5'd0) begin
      bad++;
      $display("FAIL addi got=%h exp=%h", observe(), exp_s);
    end
    drive(1, 32'h00208463, 0, 0);
    tick();
    total++;
    if (observe() !== exp_s || bus.alu_op !== 4'd8 || bus.imm !== 32'd8 ||
        bus.is_branch !== 1'b1 || bus.rf_we !== 1'b0 || bus.rd_addr !== 5'd0) begin
      bad++;
      $display("FAIL beq got=%h exp=%h", observe(), exp_s);
    end
  endtask

  task automatic test_store_lui();
    drive(1, 32'h0020A223, 0, 0);
    tick();
    total++;
    if (observe() !== exp_s || bus.mem_we !== 1'b1 || bus.imm !== 32'd4 ||
        bus.alub_sel !== 1'b1 || bus.rf_we !== 1'b0) begin
      bad++;
      $display("FAIL sw got=%h exp=%h", observe(), exp_s);
    end
    drive(1, 32'h123452B7, 0, 0);
    tick();
    total++;
    if (observe() !== exp_s || bus.imm !== 32'h1234_5000 || bus.rs1_addr !== 5'd0 ||
        bus.wd_sel !== 2'd3 || bus.rd_addr !== 5'd5) begin
      bad++;
      $display("FAIL lui got=%h exp=%h", observe(), exp_s);
    end
  endtask

  task automatic test_stall_flush();
    exp_t held;
    drive(1, 32'h002081B3, 0, 0);
    tick();
    held = exp_s;
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_inst(), 1, 0);
      tick();
      total++;
      if (observe() !== held || observe() !== exp_s) begin
        bad++;
        $display("FAIL stall_hold%0d got=%h exp=%h", i, observe(), held);
      end
    end
    drive(1, 32'h402081B3, 1, 1);
    tick();
    total++;
    if (observe() !== '0) begin
      bad++;
      $display("FAIL stall_flush got=%h exp=0", observe());
    end
  endtask

  task automatic test_illegal();
    drive(1, 32'h0000_0000, 0, 0);
    tick();
    total++;
    if (observe() !== exp_s || bus.illegal !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse got=%h exp=%h", observe(), exp_s);
    end
    drive(0, 32'h0000_0000, 0, 0);
    tick();
    total++;
    if (bus.illegal !== 1'b0) begin
      bad++;
      $display("FAIL illegal_one_cycle got=%b exp=0", bus.illegal);
    end
    drive(1, 32'h0000_0000, 0, 1);
    tick();
    total++;
    if (observe() !== '0) begin
      bad++;
      $display("FAIL illegal_flush got=%h exp=0", observe());
    end
    drive(1, 32'h0020A033, 0, 0);
    tick();
    total++;
    if (bus.illegal !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL illegal_slt got=%b/%b exp=1/0", bus.illegal, bus.out_valid);
    end
  endtask

  task automatic test_midreset();
    drive(1, 32'h002081B3, 0, 0);
    tick();
    rst_n = 1'b0;
    drive(1, 32'h402081B3, 1, 0);
    tick();
    total++;
    if (observe() !== '0) begin
      bad++;
      $display("FAIL midreset got=%h exp=0", observe());
    end
    rst_n = 1'b1;
    drive(1, 32'h402081B3, 0, 0);
    tick();
    total++;
    if (observe() !== exp_s || bus.alu_op !== 4'd1 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL after_reset got=%h exp=%h", observe(), exp_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [6] = '{32'h010000EF, 32'h00008067, 32'h00812283,
                               32'h4030D213, 32'h0030F233, 32'hFE209EE3};
    for (int i = 0; i < 6; i++) begin
      drive(1, words[i], 0, 0);
      tick();
      total++;
      if (observe() !== exp_s || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b%0d inst=%h got=%h exp=%h", i, words[i], observe(), exp_s);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, rand_inst(),
            $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      tick();
      total++;
      if (observe() !== exp_s) begin
        bad++;
        $display("FAIL random%0d got=%h exp=%h", i, observe(), exp_s);
      end
    end
  endtask

  initial begin
    r_ops['h000] = 0; r_ops['h100] = 1; r_ops['h007] = 2; r_ops['h006] = 3;
    r_ops['h004] = 4; r_ops['h001] = 5; r_ops['h005] = 6; r_ops['h105] = 7;
    i_ops[0] = 0; i_ops[7] = 2; i_ops[6] = 3; i_ops[4] = 4;
    i_ops['h001] = 5; i_ops['h005] = 6; i_ops['h105] = 7;
    b_ops[0] = 8; b_ops[1] = 9; b_ops[4] = 10; b_ops[5] = 11;
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0);
    test_reset();
    test_rtype();
    test_imm_branch();
    test_store_lui();
    test_stall_flush();
    test_illegal();
    test_midreset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
